fetch_word_reader: RTL and testbench
====================================

Name: fetch_word_reader

Overview:
- Fetch-stage reader that turns a byte-addressed PC into a word index (byte address >> 2) and reads the instruction ROM.
- Validates alignment and range, issues a single-beat read, waits a fixed ROM latency, and buffers the instruction for decode.
- Sits between the PC register and the decode stage.
- Uses valid/ready handshakes on both sides.

Parameters:
- ADDR_W, 10, width of the instruction-ROM word index; the byte space is 0 .. 2^(ADDR_W+2)-1.
- MEM_LAT, 1, ROM read latency in cycles; legal values are 1..3.
- NOP_WORD, 32'h0000_0000, instruction value returned with any fault.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  abandon the current request and any buffered output.
- req_valid  input  1  PC request valid.
- req_ready  output  1  block can accept a PC.
- pc_in  input  32  byte address of the instruction.
- imem_en  output  1  ROM read strobe, one cycle per read.
- imem_addr  output  ADDR_W  ROM word index, equal to pc[ADDR_W+1:2].
- imem_rdata  input  32  ROM data, valid MEM_LAT cycles after imem_en.
- inst_valid  output  1  instruction available for decode.
- inst_ready  input  1  decode accepts the instruction.
- inst  output  32  instruction word.
- inst_pc  output  32  byte PC belonging to inst.
- fault  output  2  00 ok, 01 misaligned, 10 out of range.

Behaviour:
- Clock and reset are fixed:
  - One clock, clk.
  - rst is synchronous and active-high.
  - While rst is high at a rising edge, the state goes to IDLE and every output register clears.
  - Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. imem_en=0, imem_addr=0, inst_valid=0, inst=0, inst_pc=0, fault=00.
  - Reset mid-read discards the read; late imem_rdata is ignored.
- States:
  - IDLE: req_ready=1.
  - ISSUE: imem_en=1 for exactly this cycle.
  - WAIT: a counter counts MEM_LAT cycles.
  - HOLD: inst_valid=1.
- Accept: a handshake (req_valid & req_ready) at edge T latches pc_in.
  - Misaligned (pc[1:0]!=0) takes priority over range.
  - If misaligned, go straight to HOLD with fault=01, inst=NOP_WORD, no ROM access. inst_valid is high in cycle T+1.
  - Else if pc[31:ADDR_W+2]!=0, same handling with fault=10.
  - Else go to ISSUE: imem_en=1 and imem_addr=pc[ADDR_W+1:2] in cycle T+1.
- WAIT:
  - The counter loads MEM_LAT-1 on entry and decrements each cycle.
  - When it reaches 0, the block samples imem_rdata (this is cycle T+1+MEM_LAT), captures it into inst with fault=00, and moves to HOLD.
  - inst_valid rises in cycle T+2+MEM_LAT; this is 3 cycles after acceptance when MEM_LAT=1.
- HOLD:
  - inst, inst_pc and fault stay stable until inst_ready=1.
  - req_ready = inst_ready, so the output buffer drains and the next PC is accepted on the same edge.
  - If no new request arrives, go to IDLE and drop inst_valid.
  - A back-to-back accept follows the accept rules above.
- Busy states: req_ready=0 in ISSUE and WAIT; there is no second outstanding read.
- flush:
  - Has priority over every other event and is ignored only under rst.
  - On the next edge: state IDLE, inst_valid=0, counter cleared. Any rdata still in flight is ignored and never surfaces.
  - req_ready=0 during the flush cycle, so a simultaneous req_valid is not accepted.
- Data and width rules:
  - No arithmetic on the PC beyond bit selection.
  - inst_pc is the exact accepted pc_in, including misaligned low bits.
  - imem_addr holds its last value when imem_en=0.
- Throughput: at most one instruction per 2+MEM_LAT cycles; faulted requests take 1 cycle.

Decomposition:
- Shared package fetch_pkg:
  - State enum {IDLE, ISSUE, WAIT, HOLD}.
  - Fault codes FAULT_OK=2'b00, FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10.
  - NOP_WORD default.
- One combinational sub-module, fetch_addr_check:
  - Inputs: pc. Outputs: word index = pc[ADDR_W+1:2], misaligned flag, range flag.
  - This is the inverse of the word-to-byte left shift used elsewhere in Fetch.
- The FSM, latency counter and output buffer stay in the top block.

Test Plan:
- Basic read, MEM_LAT=1, ROM[3]=32'h2002_0005:
  - Stimulus: req pc=0x0000_000C accepted at T, inst_ready=1.
  - Response: imem_en=1 with imem_addr=3 at T+1; inst=0x2002_0005, inst_pc=0xC, fault=00, inst_valid=1 at T+3 for one cycle.
- Misaligned PC:
  - Stimulus: pc=0x0000_0006.
  - Response: no imem_en; inst_valid at T+1 with fault=01, inst=0, inst_pc=0x6.
- Out-of-range PC:
  - Stimulus: pc=0x0000_1000 (ADDR_W=10).
  - Response: fault=10, no ROM access.
  - Also: pc=0x0000_1002 gives fault=01, confirming misalignment has priority.
- Backpressure and back-to-back:
  - Stimulus: inst_ready=0 for 4 cycles while holding pc=0x8's result, then inst_ready=1 with req pc=0x10 pending.
  - Response: outputs stay stable throughout the stall; the next accept happens on the drain edge; the following inst_valid comes 3 cycles later with ROM[4].
- Flush in WAIT, MEM_LAT=3:
  - Stimulus: flush one cycle after imem_en.
  - Response: inst_valid never rises for that PC; the block is back in IDLE with req_ready=1 the cycle after flush; a following pc=0x0 returns ROM[0].
- Reset mid-operation:
  - Stimulus: rst asserted during WAIT and during HOLD.
  - Response: all outputs are 0 the next cycle, stale rdata never appears, and normal operation resumes after rst is released.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: reader FSM states, fault codes
// and the default instruction returned with a fault.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_e;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

endpackage

// File: rtl/fetch_word_reader_if.sv
// PC request, instruction ROM and decode-side handshake
// bundle for the fetch word reader.
interface fetch_word_reader_if #(
  parameter int ADDR_W = 10
);

  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       pc_in;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic [1:0]        fault;

  modport master (
    input  flush, req_valid, pc_in,
    input  imem_rdata, inst_ready,
    output req_ready, imem_en, imem_addr,
    output inst_valid, inst, inst_pc, fault
  );

  modport slave (
    output flush, req_valid, pc_in,
    output imem_rdata, inst_ready,
    input  req_ready, imem_en, imem_addr,
    input  inst_valid, inst, inst_pc, fault
  );

endinterface

// File: rtl/fetch_addr_check.sv
// Byte PC to ROM word index, plus alignment and range flags.
// Inverse of the word-to-byte shift used elsewhere in Fetch.
module fetch_addr_check #(
  parameter int ADDR_W = 10
) (
  input  logic [31:0]       pc_i,
  output logic [ADDR_W-1:0] widx_o,
  output logic              misal_o,
  output logic              range_o
);

  assign widx_o  = pc_i[ADDR_W+1:2];
  assign misal_o = pc_i[1:0] != 2'b00;
  assign range_o = pc_i[31:ADDR_W+2] != '0;

endmodule

// File: rtl/fetch_word_reader.sv
// Fetch word reader: validates a PC, issues one ROM read,
// waits MEM_LAT cycles and buffers the word for decode.
module fetch_word_reader
  import fetch_pkg::*;
#(
  parameter int          ADDR_W   = 10,
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic clk,
  input  logic rst,
  fetch_word_reader_if.master bus
);

  localparam int CNT_W = 2;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              imem_en_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic              inst_valid_q;
  logic [31:0]       inst_q;
  logic [31:0]       inst_pc_q;
  logic [1:0]        fault_q;

  logic [ADDR_W-1:0] widx;
  logic              misal;
  logic              rng;
  logic              req_ready;
  logic              accept;

  fetch_addr_check #(
    .ADDR_W (ADDR_W)
  ) u_chk (
    .pc_i    (bus.pc_in),
    .widx_o  (widx),
    .misal_o (misal),
    .range_o (rng)
  );

  // HOLD drains and accepts on the same edge
  assign req_ready = ~rst & ~bus.flush &
                     ((state_q == IDLE) |
                      ((state_q == HOLD) & bus.inst_ready));
  assign accept    = bus.req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      imem_en_q    <= 1'b0;
      imem_addr_q  <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      fault_q      <= FAULT_OK;
    end else if (bus.flush) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      imem_en_q    <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      imem_en_q <= 1'b0;
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            inst_pc_q <= bus.pc_in;
            if (misal) begin
              state_q      <= HOLD;
              inst_valid_q <= 1'b1;
              inst_q       <= NOP_WORD;
              fault_q      <= FAULT_MISALIGN;
            end else if (rng) begin
              state_q      <= HOLD;
              inst_valid_q <= 1'b1;
              inst_q       <= NOP_WORD;
              fault_q      <= FAULT_RANGE;
            end else begin
              state_q      <= ISSUE;
              inst_valid_q <= 1'b0;
              fault_q      <= FAULT_OK;
              imem_en_q    <= 1'b1;
              imem_addr_q  <= widx;
            end
          end else if (state_q == HOLD && bus.inst_ready) begin
            state_q      <= IDLE;
            inst_valid_q <= 1'b0;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          cnt_q   <= CNT_W'(MEM_LAT - 1);
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= HOLD;
            inst_valid_q <= 1'b1;
            inst_q       <= bus.imem_rdata;
            fault_q      <= FAULT_OK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.imem_en    = imem_en_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_fetch_word_reader.sv
// Directed bench for fetch_word_reader: MEM_LAT=1 and
// MEM_LAT=3 instances, ROM models and output scoreboards.
module tb_fetch_word_reader;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;

  always #5 clk = ~clk;

  fetch_word_reader_if #(.ADDR_W(10)) b0 ();
  fetch_word_reader_if #(.ADDR_W(10)) b1 ();

  fetch_word_reader #(
    .ADDR_W(10), .MEM_LAT(1), .NOP_WORD(32'h0)
  ) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );

  fetch_word_reader #(
    .ADDR_W(10), .MEM_LAT(3), .NOP_WORD(32'h0)
  ) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  function automatic logic [31:0] rom(input logic [9:0] a);
    if (a == 10'd3) return 32'h2002_0005;
    return {16'hC0DE, 6'd0, a};
  endfunction

  // ROM models: data only during the valid cycle, poison otherwise
  logic [31:0] p0;
  logic [31:0] p1a, p1b, p1c;
  always @(posedge clk) begin
    p0  <= b0.imem_en ? rom(b0.imem_addr) : 32'hDEAD_BEEF;
    p1a <= b1.imem_en ? rom(b1.imem_addr) : 32'hDEAD_BEEF;
    p1b <= p1a;
    p1c <= p1b;
  end
  assign b0.imem_rdata = p0;
  assign b1.imem_rdata = p1c;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [31:0] i,
                              input logic [31:0] p,
                              input logic [1:0] f);
    exp_t e;
    e.inst = i;
    e.pc = p;
    e.fault = f;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && b0.inst_valid && b0.inst_ready) begin
      check("sb0_pending", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e0 = q0.pop_front();
        check("sb0_inst", b0.inst, e0.inst);
        check("sb0_pc", b0.inst_pc, e0.pc);
        check("sb0_fault", 32'(b0.fault), 32'(e0.fault));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b1.inst_valid && b1.inst_ready) begin
      check("sb1_pending", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("sb1_inst", b1.inst, e1.inst);
        check("sb1_pc", b1.inst_pc, e1.pc);
        check("sb1_fault", 32'(b1.fault), 32'(e1.fault));
      end
    end
  end

  initial begin
    b0.flush = 0; b0.req_valid = 0; b0.pc_in = 0;
    b0.inst_ready = 1;
    b1.flush = 0; b1.req_valid = 0; b1.pc_in = 0;
    b1.inst_ready = 1;

    // reset
    nxt(); nxt();
    check("rst_req_ready", 32'(b0.req_ready), 32'd0);
    check("rst_imem_en", 32'(b0.imem_en), 32'd0);
    check("rst_imem_addr", 32'(b0.imem_addr), 32'd0);
    check("rst_inst_valid", 32'(b0.inst_valid), 32'd0);
    check("rst_inst", b0.inst, 32'd0);
    check("rst_inst_pc", b0.inst_pc, 32'd0);
    check("rst_fault", 32'(b0.fault), 32'd0);
    rst = 0;
    #1;
    check("idle_req_ready", 32'(b0.req_ready), 32'd1);

    // basic read of ROM[3]
    b0.req_valid = 1; b0.pc_in = 32'hC;
    q0.push_back(mk(32'h2002_0005, 32'hC, 2'b00));
    nxt();
    b0.req_valid = 0;
    check("rd_imem_en", 32'(b0.imem_en), 32'd1);
    check("rd_imem_addr", 32'(b0.imem_addr), 32'd3);
    check("rd_busy", 32'(b0.req_ready), 32'd0);
    nxt();
    check("rd_en_once", 32'(b0.imem_en), 32'd0);
    check("rd_not_yet", 32'(b0.inst_valid), 32'd0);
    nxt();
    check("rd_valid_t3", 32'(b0.inst_valid), 32'd1);
    check("rd_inst", b0.inst, 32'h2002_0005);
    nxt();
    check("rd_drop", 32'(b0.inst_valid), 32'd0);
    check("rd_idle", 32'(b0.req_ready), 32'd1);

    // misaligned
    b0.req_valid = 1; b0.pc_in = 32'h6;
    q0.push_back(mk(32'h0, 32'h6, 2'b01));
    nxt();
    b0.req_valid = 0;
    check("mis_valid", 32'(b0.inst_valid), 32'd1);
    check("mis_no_rom", 32'(b0.imem_en), 32'd0);
    check("mis_fault", 32'(b0.fault), 32'd1);
    nxt();
    check("mis_drop", 32'(b0.inst_valid), 32'd0);

    // out of range, then back-to-back misaligned+range
    b0.req_valid = 1; b0.pc_in = 32'h1000;
    q0.push_back(mk(32'h0, 32'h1000, 2'b10));
    nxt();
    check("rng_fault", 32'(b0.fault), 32'd2);
    check("rng_no_rom", 32'(b0.imem_en), 32'd0);
    b0.pc_in = 32'h1002;
    q0.push_back(mk(32'h0, 32'h1002, 2'b01));
    #1;
    check("b2b_ready", 32'(b0.req_ready), 32'd1);
    nxt();
    b0.req_valid = 0;
    check("prio_fault", 32'(b0.fault), 32'd1);
    check("prio_valid", 32'(b0.inst_valid), 32'd1);
    nxt();
    check("prio_drop", 32'(b0.inst_valid), 32'd0);

    // backpressure then drain-edge accept
    b0.inst_ready = 0;
    b0.req_valid = 1; b0.pc_in = 32'h8;
    q0.push_back(mk(rom(10'd2), 32'h8, 2'b00));
    nxt();
    b0.req_valid = 0;
    nxt(); nxt();
    b0.req_valid = 1; b0.pc_in = 32'h10;
    q0.push_back(mk(rom(10'd4), 32'h10, 2'b00));
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_ready", 32'(b0.req_ready), 32'd0);
      check("bp_valid", 32'(b0.inst_valid), 32'd1);
      check("bp_inst", b0.inst, rom(10'd2));
      check("bp_pc", b0.inst_pc, 32'h8);
      nxt();
    end
    b0.inst_ready = 1;
    #1;
    check("drain_ready", 32'(b0.req_ready), 32'd1);
    nxt();
    b0.req_valid = 0;
    check("b2b_imem_en", 32'(b0.imem_en), 32'd1);
    check("b2b_imem_addr", 32'(b0.imem_addr), 32'd4);
    check("b2b_gap", 32'(b0.inst_valid), 32'd0);
    nxt(); nxt();
    check("b2b_valid", 32'(b0.inst_valid), 32'd1);
    check("b2b_inst", b0.inst, rom(10'd4));
    nxt();

    // flush in WAIT on the MEM_LAT=3 instance
    b1.req_valid = 1; b1.pc_in = 32'h14;
    nxt();
    b1.req_valid = 0;
    check("fl_imem_en", 32'(b1.imem_en), 32'd1);
    nxt();
    b1.flush = 1;
    b1.req_valid = 1; b1.pc_in = 32'h0;
    #1;
    check("fl_ready_low", 32'(b1.req_ready), 32'd0);
    nxt();
    b1.flush = 0;
    check("fl_idle_en", 32'(b1.imem_en), 32'd0);
    check("fl_no_valid", 32'(b1.inst_valid), 32'd0);
    #1;
    check("fl_idle_ready", 32'(b1.req_ready), 32'd1);
    q1.push_back(mk(rom(10'd0), 32'h0, 2'b00));
    nxt();
    b1.req_valid = 0;
    check("fl_rd_en", 32'(b1.imem_en), 32'd1);
    check("fl_rd_addr", 32'(b1.imem_addr), 32'd0);
    nxt(); nxt(); nxt();
    check("lat3_wait", 32'(b1.inst_valid), 32'd0);
    nxt();
    check("lat3_valid", 32'(b1.inst_valid), 32'd1);
    check("lat3_inst", b1.inst, rom(10'd0));
    nxt();

    // reset during WAIT
    b0.req_valid = 1; b0.pc_in = 32'h14;
    nxt();
    b0.req_valid = 0;
    nxt();
    rst = 1;
    nxt();
    check("rw_valid", 32'(b0.inst_valid), 32'd0);
    check("rw_en", 32'(b0.imem_en), 32'd0);
    check("rw_addr", 32'(b0.imem_addr), 32'd0);
    check("rw_pc", b0.inst_pc, 32'd0);
    rst = 0;
    nxt();
    check("rw_stale", 32'(b0.inst_valid), 32'd0);
    check("rw_ready", 32'(b0.req_ready), 32'd1);

    // reset during HOLD, then resume
    b0.inst_ready = 0;
    b0.req_valid = 1; b0.pc_in = 32'h18;
    nxt();
    b0.req_valid = 0;
    nxt(); nxt();
    check("rh_hold", 32'(b0.inst_valid), 32'd1);
    check("rh_inst", b0.inst, rom(10'd6));
    rst = 1;
    nxt();
    check("rh_valid", 32'(b0.inst_valid), 32'd0);
    check("rh_inst0", b0.inst, 32'd0);
    check("rh_pc0", b0.inst_pc, 32'd0);
    check("rh_fault0", 32'(b0.fault), 32'd0);
    check("rh_ready0", 32'(b0.req_ready), 32'd0);
    rst = 0;
    b0.inst_ready = 1;
    b0.req_valid = 1; b0.pc_in = 32'h4;
    q0.push_back(mk(rom(10'd1), 32'h4, 2'b00));
    #1;
    check("rs_ready", 32'(b0.req_ready), 32'd1);
    nxt();
    b0.req_valid = 0;
    nxt(); nxt();
    check("rs_valid", 32'(b0.inst_valid), 32'd1);
    check("rs_inst", b0.inst, rom(10'd1));
    nxt(); nxt();

    check("sb0_drained", 32'(q0.size()), 32'd0);
    check("sb1_drained", 32'(q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
